sequential_divider: RTL

- Multi-cycle unsigned restoring divider. It is the inverse operation of tree_multiplier in the 8-bit ALU datapath.
- Accepts a dividend/divisor pair on a start pulse and produces one quotient bit per clock. Signals completion with a one-cycle done pulse.
- Sits beside the multiplier in the ALU execute stage. The ALU controller drives start and samples quotient/remainder on done.

---
 rtl/sequential_divider.sv | 116 +++++++++++
 1 files changed

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, one-cycle done pulse.
// Optional macro DIVIDER_DIV0_FLAG_EN adds a div_by_zero flag and a one-cycle divide-by-zero path.
//   state | meaning
//   IDLE  | waiting for start, results held
//   CALC  | iterating, one quotient bit per edge
//   DONE  | done pulse; a start here is accepted back-to-back
module sequential_divider #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder
`ifdef DIVIDER_DIV0_FLAG_EN
    ,
    output logic            div_by_zero
`endif
);

    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [SIZE-1:0] part_rem;
    logic [SIZE-1:0] work_div;
    logic [SIZE-1:0] div_reg;

    logic [SIZE:0]   shifted;
    logic [SIZE:0]   trial;
    logic            q_bit;
    logic [SIZE-1:0] next_rem;

    // part_rem < divisor keeps the SIZE+1-bit trial in range; its MSB is the borrow
    always_comb begin
        shifted  = {part_rem, work_div[SIZE-1]};
        trial    = shifted - {1'b0, div_reg};
        q_bit    = ~trial[SIZE];
        next_rem = q_bit ? trial[SIZE-1:0] : shifted[SIZE-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            count     <= '0;
            part_rem  <= '0;
            work_div  <= '0;
            div_reg   <= '0;
`ifdef DIVIDER_DIV0_FLAG_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
`ifdef DIVIDER_DIV0_FLAG_EN
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else
`endif
                        begin
                            state    <= CALC;
                            busy     <= 1'b1;
                            div_reg  <= divisor;
                            work_div <= dividend;
                            part_rem <= '0;
                            count    <= CW'(SIZE);
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CALC: begin
                    // quotient bits enter work_div from the right as dividend bits leave on the left
                    work_div <= {work_div[SIZE-2:0], q_bit};
                    part_rem <= next_rem;
                    count    <= count - CW'(1);
                    if (count == CW'(1)) begin
                        quotient  <= {work_div[SIZE-2:0], q_bit};
                        remainder <= next_rem;
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
